// File: rtl/f15_histo_rmw_if.sv
// Update-beat handshake for the fosphor histogram read-modify-write controller.
//   in_addr  : cell to update
//   in_mode  : 0 = rise, 1 = decay
//   in_ena   : 0 = write the original value back unchanged
//   in_valid : beat valid (producer)
//   in_ready : beat accepted when in_valid & in_ready (controller)
// master = beat producer, slave = f15_histo_rmw.
interface f15_histo_rmw_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_mode;
  logic                  in_ena;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_addr, in_mode, in_ena, in_valid, input in_ready);
  modport slave  (input in_addr, in_mode, in_ena, in_valid, output in_ready);
endinterface

// File: rtl/f15_histo_rmw.sv
// Read-modify-write controller for the fosphor histogram cell memory.
// A beat accepted at t reads its cell (1-cycle RAM), hands the value to
// f15_rise_decay at t+1 and writes rd_out_5 back to the same cell at t+6.
// Beats whose address is still in flight are stalled. The whole memory is
// zero-filled after reset and on clr_req, once the pipeline has drained.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   beat                update-beat handshake (slave side)
//   clr_req / clr_busy  clear request pulse / busy while draining or clearing
//   mem_rd_*            RAM read port (data valid one cycle after mem_rd_en)
//   mem_we, mem_wr_*    RAM write port
//   rd_in_0/mode_0/ena_0  to f15_rise_decay stage 0
//   rd_out_5            from f15_rise_decay stage 5
module f15_histo_rmw #(
  parameter int WIDTH      = 9,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  f15_histo_rmw_if.slave        beat,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]      mem_rd_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]      mem_wr_data,
  output logic [WIDTH-1:0]      rd_in_0,
  output logic                  rd_mode_0,
  output logic                  rd_ena_0,
  input  logic [WIDTH-1:0]      rd_out_5
);
  // Stage p1 is the rise/decay input cycle, p6 the writeback cycle.
  localparam int STAGES = 6;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t                state;
  logic [STAGES:1]       vld_pipe;
  logic [ADDR_WIDTH-1:0] addr_pipe [1:STAGES];
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  hazard;
  logic                  ready;
  logic                  accept;

  // The RAM is read-first, so a cell is safe to read again only once its
  // writeback stage has retired: compare against every live stage.
  always_comb begin
    hazard = 1'b0;
    for (int i = 1; i <= STAGES; i++)
      if (vld_pipe[i] && addr_pipe[i] == beat.in_addr) hazard = 1'b1;
    hazard = hazard & beat.in_valid;
  end

  // A clr_req cycle accepts nothing so the drain sees a stable pipeline.
  assign ready         = ~rst & (state == RUN) & ~clr_req & ~hazard;
  assign beat.in_ready = ready;
  assign accept        = beat.in_valid & ready;

  assign mem_rd_en   = accept;
  assign mem_rd_addr = accept ? beat.in_addr : '0;
  assign rd_in_0     = mem_rd_data;
  assign clr_busy    = (state != RUN);

  // The pipeline is empty whenever CLEAR is active, so the write port never
  // needs arbitration.
  always_comb begin
    mem_we      = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (state == CLEAR) begin
      mem_we      = 1'b1;
      mem_wr_addr = clr_cnt;
    end else if (vld_pipe[STAGES]) begin
      mem_we      = 1'b1;
      mem_wr_addr = addr_pipe[STAGES];
      mem_wr_data = rd_out_5;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DRAIN;
      clr_cnt   <= '0;
      vld_pipe  <= '0;
      rd_mode_0 <= 1'b0;
      rd_ena_0  <= 1'b0;
      for (int i = 1; i <= STAGES; i++) addr_pipe[i] <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], accept};
      addr_pipe[1] <= accept ? beat.in_addr : '0;
      for (int i = 2; i <= STAGES; i++) addr_pipe[i] <= addr_pipe[i-1];
      rd_mode_0    <= accept & beat.in_mode;
      rd_ena_0     <= accept & beat.in_ena;

      case (state)
        RUN:   if (clr_req) state <= DRAIN;
        DRAIN: if (vld_pipe == '0) begin
                 state   <= CLEAR;
                 clr_cnt <= '0;
               end
        CLEAR: begin
                 clr_cnt <= clr_cnt + 1'b1;
                 if (&clr_cnt) state <= RUN;
               end
        default: state <= DRAIN;
      endcase
    end
  end
endmodule

// File: tb/tb_f15_histo_rmw.sv
module tb_f15_histo_rmw;
  localparam int WIDTH = 9;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  f15_histo_rmw_if #(.ADDR_WIDTH(AW)) bus();

  logic             clr_req, clr_busy, mem_rd_en, mem_we, rd_mode_0, rd_ena_0;
  logic [AW-1:0]    mem_rd_addr, mem_wr_addr;
  logic [WIDTH-1:0] mem_rd_data, mem_wr_data, rd_in_0, rd_out_5;

  f15_histo_rmw #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .beat(bus.slave),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .rd_in_0(rd_in_0), .rd_mode_0(rd_mode_0), .rd_ena_0(rd_ena_0),
    .rd_out_5(rd_out_5)
  );

  // Rise/decay rule used both by the stand-in stage and by the reference.
  function automatic int rd_fn(int v, bit mode, bit ena);
    if (!ena) return v;
    if (mode) return v - (v >> 3);
    return (v + 32 > 511) ? 511 : v + 32;
  endfunction

  // Environment: read-first 1-cycle RAM with a poke port, 5-stage rise/decay.
  logic [WIDTH-1:0] ram [DEPTH];
  logic             poke_en = 1'b0;
  logic [AW-1:0]    poke_addr = '0;
  logic [WIDTH-1:0] poke_data = '0;
  logic [WIDTH-1:0] rdp [1:5];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    if (mem_we)    ram[mem_wr_addr] <= mem_wr_data;
    if (poke_en)   ram[poke_addr] <= poke_data;
  end

  always @(posedge clk) begin
    rdp[1] <= WIDTH'(rd_fn(int'(rd_in_0), rd_mode_0, rd_ena_0));
    for (int k = 2; k <= 5; k++) rdp[k] <= rdp[k-1];
  end
  assign rd_out_5 = rdp[5];

  // Reference model: sequential cell memory plus a list of due writebacks.
  typedef struct { int due; int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  ref_mem [DEPTH];
  bit  busy = 1'b1;
  int  clr_cnt = 0, clr_first = 0, clr_last = 0;
  int  cyc = 0, n_chk = 0, n_err = 0;
  bit  exp_ena0 = 1'b0, exp_mode0 = 1'b0, acc_flag = 1'b0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: check everything at the negedge, update the model, advance.
  task automatic tick();
    bit hz;
    int a;
    @(negedge clk);
    acc_flag = 1'b0;
    if (rst) begin
      busy = 1'b1; clr_cnt = 0; exp_q.delete();
      exp_ena0 = 1'b0; exp_mode0 = 1'b0;
    end else begin
      chk("clr_busy", int'(clr_busy), int'(busy));
      hz = 1'b0;
      foreach (exp_q[i]) if (bus.in_valid && exp_q[i].addr == int'(bus.in_addr)) hz = 1'b1;
      chk("in_ready", int'(bus.in_ready), int'(!busy && !clr_req && !hz));
      chk("rd_ena_0", int'(rd_ena_0), int'(exp_ena0));
      chk("rd_mode_0", int'(rd_mode_0), int'(exp_mode0));
      acc_flag = bus.in_valid && bus.in_ready;
      chk("mem_rd_en", int'(mem_rd_en), int'(acc_flag));
      if (acc_flag) chk("mem_rd_addr", int'(mem_rd_addr), int'(bus.in_addr));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("wb_we", int'(mem_we), 1);
        chk("wb_addr", int'(mem_wr_addr), exp_q[0].addr);
        chk("wb_data", int'(mem_wr_data), exp_q[0].data);
        void'(exp_q.pop_front());
      end else if (mem_we) begin
        chk("clr_write_allowed", int'(busy && exp_q.size() == 0), 1);
        chk("clr_addr", int'(mem_wr_addr), clr_cnt);
        chk("clr_data", int'(mem_wr_data), 0);
        if (clr_cnt == 0) clr_first = cyc;
        clr_last = cyc;
        clr_cnt++;
        if (clr_cnt == DEPTH) begin
          busy = 1'b0; clr_cnt = 0;
          foreach (ref_mem[i]) ref_mem[i] = 0;
        end
      end
      exp_ena0  = acc_flag && bus.in_ena;
      exp_mode0 = acc_flag && bus.in_mode;
      if (acc_flag) begin
        a = int'(bus.in_addr);
        ref_mem[a] = rd_fn(ref_mem[a], bus.in_mode, bus.in_ena);
        exp_q.push_back('{cyc + 6, a, ref_mem[a]});
      end
      if (clr_req && !busy) begin busy = 1'b1; clr_cnt = 0; end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(int limit);
    int n = 0;
    while (busy && n < limit) begin tick(); n++; end
    chk("clear_done_in_time", int'(busy), 0);
  endtask

  task automatic check_reset();
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_clr_busy", int'(clr_busy), 1);
    chk("rst_mem_rd_en", int'(mem_rd_en), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_rd_mode_0", int'(rd_mode_0), 0);
    chk("rst_rd_ena_0", int'(rd_ena_0), 0);
    chk("rst_addrs", int'(mem_rd_addr) + int'(mem_wr_addr), 0);
    chk("rst_wr_data", int'(mem_wr_data), 0);
  endtask

  task automatic poke(int a, int d);
    poke_en = 1'b1; poke_addr = AW'(a); poke_data = WIDTH'(d);
    tick();
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic send(int a, bit m, bit e);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_addr = AW'(a); bus.in_mode = m; bus.in_ena = e;
    do begin tick(); n++; end while (!acc_flag && n < 50);
    chk("send_accepted", int'(acc_flag), 1);
    bus.in_valid = 1'b0;
  endtask

  typedef struct { int addr; bit mode; bit ena; int init; int exp; } vec_t;
  vec_t vecs [8];

  initial begin
    int n;
    vecs[0] = '{3,  1'b0, 1'b0, 'h1A5, 'h1A5};
    vecs[1] = '{20, 1'b0, 1'b1, 'h010, 'h030};
    vecs[2] = '{21, 1'b0, 1'b1, 'h1F0, 'h1FF};
    vecs[3] = '{22, 1'b1, 1'b1, 'h100, 'h0E0};
    vecs[4] = '{23, 1'b1, 1'b1, 'h007, 'h007};
    vecs[5] = '{24, 1'b1, 1'b0, 'h0AA, 'h0AA};
    vecs[6] = '{25, 1'b0, 1'b1, 'h1FF, 'h1FF};
    vecs[7] = '{26, 1'b1, 1'b1, 'h1A5, 'h171};

    bus.in_valid = 1'b1; bus.in_addr = AW'(9); bus.in_mode = 1'b0; bus.in_ena = 1'b1;
    clr_req = 1'b0;

    // Reset with a beat offered: nothing may be accepted.
    repeat (3) tick();
    check_reset();
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // Automatic clear after reset.
    run_until_idle(1200);
    chk("clr_span", clr_last - clr_first + 1, DEPTH);
    chk("idle_clr_busy", int'(clr_busy), 0);
    chk("idle_in_ready", int'(bus.in_ready), 1);

    // Back-to-back beats to distinct addresses.
    bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_ena = 1'b1;
    for (int a = 5; a <= 7; a++) begin
      bus.in_addr = AW'(a);
      tick();
      chk("b2b_accept", int'(acc_flag), 1);
    end
    bus.in_valid = 1'b0;
    repeat (10) tick();
    chk("b2b_cell7", int'(ram[7]), 32);

    // Read-after-write hazard on cell 12.
    poke(12, 'h40);
    bus.in_valid = 1'b1; bus.in_addr = AW'(12); bus.in_mode = 1'b0; bus.in_ena = 1'b1;
    tick();
    chk("raw_first_accept", int'(acc_flag), 1);
    bus.in_mode = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_flag && n < 20);
    chk("raw_stall_cycles", n - 1, 6);
    bus.in_valid = 1'b0;
    repeat (10) tick();
    chk("raw_final", int'(ram[12]), 'h54);

    // Table of single beats with known cell contents.
    foreach (vecs[i]) begin
      poke(vecs[i].addr, vecs[i].init);
      send(vecs[i].addr, vecs[i].mode, vecs[i].ena);
      repeat (6) tick();
      chk($sformatf("vec%0d_cell", i), int'(ram[vecs[i].addr]), vecs[i].exp);
    end
    repeat (4) tick();

    // Clear request with three beats in flight and a fourth waiting.
    bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_ena = 1'b1;
    for (int a = 40; a <= 42; a++) begin
      bus.in_addr = AW'(a);
      tick();
    end
    bus.in_addr = AW'(43); clr_req = 1'b1;
    tick();
    chk("clr_req_cycle_no_accept", int'(acc_flag), 0);
    clr_req = 1'b0;
    run_until_idle(1200);
    tick();
    chk("after_clear_accept", int'(acc_flag), 1);
    bus.in_valid = 1'b0;
    repeat (10) tick();
    chk("after_clear_cell43", int'(ram[43]), 32);
    chk("cleared_cell40", int'(ram[40]), 0);

    // Reset in the middle of a clear.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_cnt < 300 && n < 1200) begin tick(); n++; end
    chk("reached_clr_300", clr_cnt, 300);
    rst = 1'b1;
    repeat (2) tick();
    check_reset();
    rst = 1'b0;
    run_until_idle(1200);
    chk("restart_clr_span", clr_last - clr_first + 1, DEPTH);

    // Random traffic on a small address range to provoke hazards.
    bus.in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!bus.in_valid || acc_flag) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_addr  = AW'($urandom_range(0, 7));
        bus.in_mode  = 1'($urandom_range(0, 1));
        bus.in_ena   = ($urandom_range(0, 4) != 0);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (10) tick();
    chk("all_writebacks_seen", exp_q.size(), 0);
    for (int a = 0; a < 8; a++) chk($sformatf("rand_cell%0d", a), int'(ram[a]), ref_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
